reg_write_decoder: RTL
======================

REG_WRITE_DECODER -- requirements
Module: reg_write_decoder

Interface
REQ-001 Parameter: WIDTH, default 64, write-data width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 wr_en  input  1  writeback request valid this cycle.
REQ-005 wr_addr  input  5  destination register of writeback.
REQ-006 wr_data  input  WIDTH  writeback data.
REQ-007 rsv_en  input  1  issue stage reserves a destination register.
REQ-008 rsv_addr  input  5  register being reserved.
REQ-009 rd_addr_a, rd_addr_b  input  5 each  source registers to hazard-check.
REQ-010 reg_we  output  32  registered one-hot write enable, bit i = register i.
REQ-011 reg_wdata  output  WIDTH  registered write data aligned with reg_we.
REQ-012 busy  output  32  scoreboard, bit i set = write to register i pending.
REQ-013 stall  output  1  combinational: busy[rd_addr_a] or busy[rd_addr_b].

Function
REQ-014 Decode: wr_en=1 and wr_addr!=31 SHALL drive reg_we = (1 << wr_addr) on the next cycle; otherwise reg_we = 0.
REQ-015 Latency SHALL be exactly 1 cycle from wr_en/wr_addr/wr_data to reg_we/reg_wdata; reg_wdata SHALL capture wr_data every cycle wr_en=1 and hold otherwise.
REQ-016 reg_we SHALL have at most one bit set in every cycle; bit 31 SHALL never be set (XZR).
REQ-017 Scoreboard set: rsv_en=1 and rsv_addr!=31 SHALL set busy[rsv_addr] at the next edge.
REQ-018 Scoreboard clear: wr_en=1 and wr_addr!=31 SHALL clear busy[wr_addr] at the next edge.
REQ-019 Simultaneous set and clear of the same register SHALL leave the bit set (new producer wins).
REQ-020 Set and clear of different registers in one cycle SHALL both take effect.
REQ-021 busy[31] SHALL be constant 0; reservation of 31 SHALL be ignored.
REQ-022 Re-reserving an already busy register SHALL leave it set; clearing a non-busy register SHALL leave it clear, no error.
REQ-023 stall SHALL ignore address 31 and SHALL reflect busy as registered at the current edge (no same-cycle bypass of wr_en).
REQ-024 Per-register selection SHALL use a 5-to-32 one-hot decode; no priority encoding.

Reset
REQ-025 reset=1 at a rising edge SHALL force reg_we=0, reg_wdata=0, busy=0, overriding wr_en and rsv_en in the same cycle.
REQ-026 A writeback or reservation presented during reset SHALL be lost; first valid request is accepted on the first edge after reset deasserts.

Structure
REQ-027 Package regfile_pkg SHALL hold NUM_REGS=32, ADDR_W=5, XZR_ADDR=5'd31, shared with the register-file read path.
REQ-028 One sub-module decoder5_32 (combinational: 5-bit addr + enable -> 32-bit one-hot) SHALL be instantiated twice: writeback decode and reservation decode.

Verification
REQ-029 Reset then wr_en=1, wr_addr=5, wr_data=0xDEAD -> next cycle reg_we=0x00000020, reg_wdata=0xDEAD; following cycle reg_we=0.
REQ-030 wr_en=1, wr_addr=31 -> reg_we=0 next cycle; rsv_en=1, rsv_addr=31 -> busy stays 0.
REQ-031 rsv_en addr 3, then rd_addr_a=3 -> stall=1; wr_en addr 3 -> busy[3]=0 and stall=0 the cycle after.
REQ-032 busy[7]=1, same cycle rsv_en addr 7 and wr_en addr 7 -> busy[7] remains 1; rsv addr 8 + wr addr 7 -> busy[8]=1, busy[7]=0.
REQ-033 Sweep wr_addr 0..31 with wr_en=1 -> reg_we one-hot matching addr for 0..30, 0 for 31, checked every cycle.
REQ-034 busy=0x0000_00FF, assert reset with wr_en=1 addr 2 -> next cycle busy=0, reg_we=0, reg_wdata=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants, also used by the register-file read path.
//   NUM_REGS  : number of architectural registers
//   ADDR_W    : register address width
//   XZR_ADDR  : zero register. It is never written and never tracked as busy.
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam logic [ADDR_W-1:0] XZR_ADDR = 5'd31;

    // True for any register that can really hold a value, which excludes XZR.
    function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
        return addr != XZR_ADDR;
    endfunction

endpackage

// File: rtl/decoder5_32.sv
// Combinational 5-to-32 one-hot decoder with an enable input.
//   en     : the decode is active only when en is high
//   addr   : register address
//   onehot : bit addr is set when en=1. The output stays all-zero for XZR.
module decoder5_32
    import regfile_pkg::*;
(
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en && is_writable(addr)) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_write_decoder.sv
// Writeback decoder and busy-register scoreboard for the register file.
//   clk, reset          : single clock, synchronous active-high reset
//   wr_en/addr/data     : writeback request
//   rsv_en/addr         : issue-stage reservation of a destination register
//   rd_addr_a/b         : source registers checked for a RAW hazard
//   reg_we              : registered one-hot write enable. It is never set for XZR.
//   reg_wdata           : registered write data. It holds its value when wr_en=0.
//   busy                : scoreboard of pending writes
//   stall               : combinational hazard flag taken from the registered busy
module reg_write_decoder
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [NUM_REGS-1:0] reg_we,
    output logic [WIDTH-1:0]    reg_wdata,
    output logic [NUM_REGS-1:0] busy,
    output logic                stall
);

    logic [NUM_REGS-1:0] wr_onehot;
    logic [NUM_REGS-1:0] rsv_onehot;

    decoder5_32 u_wr_dec (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (wr_onehot)
    );

    decoder5_32 u_rsv_dec (
        .en     (rsv_en),
        .addr   (rsv_addr),
        .onehot (rsv_onehot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_we    <= '0;
            reg_wdata <= '0;
            busy      <= '0;
        end else begin
            reg_we <= wr_onehot;
            if (wr_en) begin
                reg_wdata <= wr_data;
            end
            // The clear is applied before the set, so a new reservation on the
            // register being written back in the same cycle keeps its bit set.
            busy <= (busy & ~wr_onehot) | rsv_onehot;
        end
    end

    // The decoders never produce bit XZR, so busy[31] stays zero.
    always_comb begin
        stall = (is_writable(rd_addr_a) && busy[rd_addr_a]) ||
                (is_writable(rd_addr_b) && busy[rd_addr_b]);
    end

endmodule
